// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder built around one reused full-adder cell; optional Overflow output under SERIAL_ADDER_OVERFLOW_EN
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic carry, s_bit, c_bit, last;
  assign s_bit = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_bit = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign last = cnt == CW'(WIDTH - 1);
  assign Busy = state != IDLE;
  // Sequencer: capture operands, ripple one bit per cycle LSB first, then publish the result
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt <= '0;
      a_sh <= '0;
      b_sh <= '0;
      res <= '0;
      carry <= 1'b0;
      Sum <= '0;
      Cout <= 1'b0;
      Done <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (state == IDLE) begin
        if (Start) begin
          a_sh <= A;
          b_sh <= B;
          carry <= Cin;
          cnt <= '0;
          state <= ADD;
        end
      end else if (state == ADD) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        res <= {s_bit, res[WIDTH-1:1]};
        carry <= c_bit;
        cnt <= cnt + CW'(1);
        state <= last ? FINISH : ADD;
      end else begin
        Sum <= res;
        Cout <= carry;
        Done <= 1'b1;
        state <= IDLE;
      end
    end
  end
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic c_msb;
  // Overflow compares the carry entering the MSB cell with the carry leaving it
  always_ff @(posedge Clk) begin
    if (Rst) begin
      c_msb <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      if (state == ADD && last) c_msb <= carry;
      if (state == FINISH) Overflow <= c_msb ^ carry;
    end
  end
`endif
endmodule
